// File: rtl/pwm_multi_ch.sv
// rtl/pwm_multi_ch.sv - multi-channel PWM with shared prescaler/counter and shadowed duties
// Optional center-aligned mode built only when PWM_CENTER_ALIGN_EN is defined.
module pwm_multi_ch #(
  parameter int SYS_FREQ = 125,
  parameter int CH       = 4,
  parameter int N        = 8,
  parameter int PW       = 16,
  parameter int CW       = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          enable,
  input  logic          center,
  input  logic [PW-1:0] prescale,
  input  logic          wr_en,
  input  logic [CW-1:0] wr_ch,
  input  logic [N:0]    wr_duty,
  output logic [CH-1:0] pwm,
  output logic [CH-1:0] pending,
  output logic          period_start
);

  localparam logic [N-1:0] CNT_MAX = '1;
  localparam int unused_sys_freq = SYS_FREQ;

  logic [PW-1:0] pre_cnt;
  logic [N-1:0]  cnt;
  logic          tick;
  logic          boundary;
  logic [N:0]    shadow [CH];
  logic [N:0]    active [CH];

  // A prescale lowered below pre_cnt still ticks at once because of the >= compare.
  assign tick = enable && (pre_cnt >= prescale);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_cnt <= '0;
    end else if (!enable || tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

`ifdef PWM_CENTER_ALIGN_EN
  logic dir_down;
  logic mode_c;

  // mode_c samples the center input only at a period boundary or while idle.
  always_comb begin
    boundary = 1'b0;
    if (tick) begin
      if (mode_c) boundary = dir_down && (cnt == N'(1));
      else        boundary = (cnt == CNT_MAX);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt      <= '0;
      dir_down <= 1'b0;
      mode_c   <= 1'b0;
    end else if (!enable) begin
      cnt      <= '0;
      dir_down <= 1'b0;
      mode_c   <= center;
    end else if (tick) begin
      if (boundary) mode_c <= center;
      if (!mode_c) begin
        cnt      <= cnt + 1'b1;
        dir_down <= 1'b0;
      end else if (!dir_down) begin
        if (cnt == CNT_MAX) begin
          cnt      <= CNT_MAX - 1'b1;
          dir_down <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= cnt - 1'b1;
        if (cnt == N'(1)) dir_down <= 1'b0;
      end
    end
  end
`else
  logic unused_center;
  assign unused_center = center;
  assign boundary      = tick && (cnt == CNT_MAX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (!enable) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= cnt + 1'b1;
    end
  end
`endif

  // Write after boundary so a same-cycle write stays pending (set beats clear).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < CH; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
      pending      <= '0;
      pwm          <= '0;
      period_start <= 1'b0;
    end else begin
      period_start <= boundary;
      for (int i = 0; i < CH; i++) begin
        pwm[i] <= enable && ({1'b0, cnt} < active[i]);
        if (!enable || (boundary && pending[i])) begin
          active[i]  <= shadow[i];
          pending[i] <= 1'b0;
        end
        if (wr_en && (wr_ch == CW'(i))) begin
          shadow[i]  <= wr_duty;
          pending[i] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pwm_multi_ch.sv
// tb/tb_pwm_multi_ch.sv - directed plus random checks of pwm_multi_ch against a timeline model
// Works with or without PWM_CENTER_ALIGN_EN defined.
module tb_pwm_multi_ch;
  localparam int CH  = 5;
  localparam int N   = 4;
  localparam int PW  = 8;
  localparam int CW  = 3;
  localparam int LIM = 2 ** N;

  logic          clk = 1'b0;
  logic          reset_n, enable, center, wr_en;
  logic [PW-1:0] prescale;
  logic [CW-1:0] wr_ch;
  logic [N:0]    wr_duty;
  logic [CH-1:0] pwm, pending;
  logic          period_start;

  int vectors = 0;
  int miscompares = 0;

  int            m_active [CH];
  int            m_shadow [CH];
  logic [CH-1:0] m_pend, exp_pwm;
  logic          exp_ps;
  int            t;
  bit            m_center;
  int            hi_cnt [CH];
  int            ps_cnt;
  bit            seen;

  always #4 clk = ~clk;

  pwm_multi_ch #(.SYS_FREQ(125), .CH(CH), .N(N), .PW(PW), .CW(CW)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .center(center),
    .prescale(prescale), .wr_en(wr_en), .wr_ch(wr_ch), .wr_duty(wr_duty),
    .pwm(pwm), .pending(pending), .period_start(period_start)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  function automatic bit cen_eff();
`ifdef PWM_CENTER_ALIGN_EN
    return center;
`else
    return 1'b0;
`endif
  endfunction

  // Period length in clocks and counter position at clock t of the period.
  function automatic int plen();
    return (int'(prescale) + 1) * (m_center ? 2 * LIM - 2 : LIM);
  endfunction

  function automatic int pos(input int tt);
    int s;
    s = tt / (int'(prescale) + 1);
    if (!m_center || s < LIM) return s;
    return 2 * LIM - 2 - s;
  endfunction

  task automatic model_reset();
    t = 0; m_center = 0; exp_pwm = '0; exp_ps = 0; m_pend = '0;
    for (int i = 0; i < CH; i++) begin
      m_active[i] = 0;
      m_shadow[i] = 0;
    end
  endtask

  task automatic model_step();
    int p;
    bit bnd;
    if (!reset_n) begin
      model_reset();
      return;
    end
    if (!enable) begin
      t = 0; exp_pwm = '0; exp_ps = 0; m_pend = '0; m_center = cen_eff();
      for (int i = 0; i < CH; i++) m_active[i] = m_shadow[i];
    end else begin
      p = pos(t);
      for (int i = 0; i < CH; i++) exp_pwm[i] = (p < m_active[i]);
      bnd = (t == plen() - 1);
      exp_ps = bnd;
      if (bnd) begin
        for (int i = 0; i < CH; i++)
          if (m_pend[i]) begin
            m_active[i] = m_shadow[i];
            m_pend[i] = 1'b0;
          end
        t = 0;
        m_center = cen_eff();
      end else begin
        t++;
      end
    end
    if (wr_en && int'(wr_ch) < CH) begin
      m_shadow[int'(wr_ch)] = int'(wr_duty);
      m_pend[int'(wr_ch)] = 1'b1;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    chk("pwm", 64'(pwm), 64'(exp_pwm));
    chk("pending", 64'(pending), 64'(m_pend));
    chk("period_start", 64'(period_start), 64'(exp_ps));
  endtask

  task automatic write(input int ch, input int d);
    wr_en = 1; wr_ch = CW'(ch); wr_duty = (N+1)'(d);
    cycle();
    wr_en = 0;
  endtask

  task automatic wait_ps();
    seen = 0;
    for (int k = 0; k < 300 && !seen; k++) begin
      cycle();
      if (period_start) seen = 1;
    end
    chk("period_start_timeout", 64'(seen), 64'(1));
  endtask

  task automatic run_period(input int len, input int wj, input int wch, input int wd);
    ps_cnt = 0;
    for (int i = 0; i < CH; i++) hi_cnt[i] = 0;
    for (int j = 0; j < len; j++) begin
      if (j == wj) begin
        wr_en = 1; wr_ch = CW'(wch); wr_duty = (N+1)'(wd);
      end
      cycle();
      wr_en = 0;
      for (int i = 0; i < CH; i++) hi_cnt[i] += int'(pwm[i]);
      ps_cnt += int'(period_start);
    end
  endtask

  initial begin
    reset_n = 0; enable = 0; center = 0; prescale = '0;
    wr_en = 0; wr_ch = '0; wr_duty = '0;
    model_reset();
    #2;
    chk("reset_pwm", 64'(pwm), 64'(0));
    chk("reset_pending", 64'(pending), 64'(0));
    chk("reset_pstart", 64'(period_start), 64'(0));
    cycle(); cycle();
    reset_n = 1; enable = 1;
    repeat (40) cycle();
    chk("idle_pwm", 64'(pwm), 64'(0));

    enable = 0; prescale = 1;
    cycle();
    enable = 1;
    write(0, 5);
    wait_ps();
    run_period(32, -1, 0, 0);
    chk("edge_hi_ch0", 64'(hi_cnt[0]), 64'(10));
    chk("edge_ps_count", 64'(ps_cnt), 64'(1));

    write(1, 0); write(2, 16); write(3, 15);
    wait_ps();
    run_period(32, -1, 0, 0);
    chk("limit_ch1", 64'(hi_cnt[1]), 64'(0));
    chk("limit_ch2", 64'(hi_cnt[2]), 64'(32));
    chk("limit_ch3", 64'(hi_cnt[3]), 64'(30));

    write(0, 4);
    wait_ps();
    run_period(32, 5, 0, 12);
    chk("glitch_keep4", 64'(hi_cnt[0]), 64'(8));
    run_period(32, 31, 0, 7);
    chk("glitch_new12", 64'(hi_cnt[0]), 64'(24));
    chk("bnd_write_pending", 64'(pending[0]), 64'(1));
    run_period(32, -1, 0, 0);
    chk("bnd_write_held", 64'(hi_cnt[0]), 64'(24));
    run_period(32, -1, 0, 0);
    chk("bnd_write_applied", 64'(hi_cnt[0]), 64'(14));

    repeat (7) cycle();
    @(negedge clk);
    reset_n = 0;
    #1;
    model_reset();
    chk("async_reset_pwm", 64'(pwm), 64'(0));
    chk("async_reset_pending", 64'(pending), 64'(0));
    cycle();
    reset_n = 1; enable = 1; prescale = 0;
    repeat (40) cycle();
    chk("post_reset_pwm", 64'(pwm), 64'(0));

`ifdef PWM_CENTER_ALIGN_EN
    enable = 0; center = 1; prescale = 0;
    write(0, 4);
    cycle();
    enable = 1;
    wait_ps();
    run_period(30, -1, 0, 0);
    chk("center_hi_ch0", 64'(hi_cnt[0]), 64'(7));
    chk("center_ps_count", 64'(ps_cnt), 64'(1));
`endif

    write(0, 20);
    wait_ps();
    repeat (5) cycle();
    chk("full_duty_on", 64'(pwm[0]), 64'(1));
    enable = 0;
    cycle();
    chk("disable_pwm", 64'(pwm), 64'(0));
    enable = 1;
    write(5, 9);
    write(7, 3);
    chk("invalid_ch_pending", 64'(pending), 64'(0));

    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 199) < 2) begin
        enable = 0;
        prescale = PW'($urandom_range(0, 2));
      end else begin
        enable = 1;
      end
      if ($urandom_range(0, 59) == 0) center = ~center;
      wr_en = ($urandom_range(0, 5) == 0);
      wr_ch = CW'($urandom_range(0, 7));
      wr_duty = (N+1)'($urandom_range(0, 31));
      cycle();
    end
    wr_en = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
